// File: rtl/ysyx_22051013_mul_ctrl.sv
// EXE-stage sequencer for the radix-4 Booth multiplier.
// Decodes RV64M multiply ops, runs the start/result handshake with the
// multiplier, selects the hi/lo half (sign-extending MULW), and keeps a
// one-entry product cache so a MULH*/MUL pair on the same operands only
// multiplies once.
//
// Handshakes: an op moves on a cycle where in_valid & in_ready & ~flush.
// A result moves on a cycle where res_valid & res_ready. Once res_valid is
// raised, res_data holds until that transfer or a flush.
module ysyx_22051013_mul_ctrl #(
    parameter int XLEN     = 64,
    parameter bit REUSE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      mul_op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic            m_valid,
    output logic [1:0]      m_signed,
    output logic            m_mulw,
    output logic [XLEN-1:0] m_op1,
    output logic [XLEN-1:0] m_op2,
    output logic            m_flush,
    input  logic            m_ready,
    input  logic            m_out_valid,
    input  logic [XLEN-1:0] m_hi,
    input  logic [XLEN-1:0] m_lo
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_MULW   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [2:0]      op_q;

    // Product cache: last completed multiply, kept across flushes.
    logic            cache_valid;
    logic [XLEN-1:0] cache_op1;
    logic [XLEN-1:0] cache_op2;
    logic [1:0]      cache_signed;
    logic            cache_mulw;
    logic [XLEN-1:0] cache_hi;
    logic [XLEN-1:0] cache_lo;

    logic            accept;
    logic            op_legal;
    logic            op_is_high;
    logic [1:0]      in_signed;
    logic            in_mulw;
    logic            cache_hit;

    assign in_ready = (state == S_IDLE) & m_ready;
    assign m_flush  = flush;
    assign accept   = in_valid & in_ready & ~flush;

    // Decode the incoming op: legality, signedness, word mode, cache hit.
    always_comb begin
        op_legal   = (mul_op <= OP_MULW);
        op_is_high = (mul_op == OP_MULH) | (mul_op == OP_MULHSU) | (mul_op == OP_MULHU);
        in_mulw    = (mul_op == OP_MULW);
        in_signed  = 2'b11;
        if (mul_op == OP_MULHSU) begin
            in_signed = 2'b01;
        end else if (mul_op == OP_MULHU) begin
            in_signed = 2'b00;
        end
        // The low half does not depend on signedness, so MUL reuses any
        // cached 64x64 product; the high half only matches the same signedness.
        cache_hit = REUSE_EN & cache_valid & ~cache_mulw &
                    (src1 == cache_op1) & (src2 == cache_op2) &
                    ((mul_op == OP_MUL) | (op_is_high & (in_signed == cache_signed)));
    end

    // Sequencer FSM with registered handshake, operand and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= OP_MUL;
            res_valid    <= 1'b0;
            res_data     <= '0;
            m_valid      <= 1'b0;
            m_signed     <= 2'b00;
            m_mulw       <= 1'b0;
            m_op1        <= '0;
            m_op2        <= '0;
            cache_valid  <= 1'b0;
            cache_op1    <= '0;
            cache_op2    <= '0;
            cache_signed <= 2'b00;
            cache_mulw   <= 1'b0;
            cache_hi     <= '0;
            cache_lo     <= '0;
        end else if (flush) begin
            // Flush kills whatever is in flight; the cache is left intact.
            state     <= S_IDLE;
            m_valid   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= mul_op;
                        if (!op_legal) begin
                            res_data  <= '0;
                            res_valid <= 1'b1;
                            state     <= S_DONE;
                        end else if (cache_hit) begin
                            res_data  <= (mul_op == OP_MUL) ? cache_lo : cache_hi;
                            res_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            m_op1    <= src1;
                            m_op2    <= src2;
                            m_signed <= in_signed;
                            m_mulw   <= in_mulw;
                            m_valid  <= 1'b1;
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    m_valid <= 1'b0;
                    state   <= S_BUSY;
                end
                S_BUSY: begin
                    if (m_out_valid) begin
                        case (op_q)
                            OP_MUL:  res_data <= m_lo;
                            OP_MULW: res_data <= {{(XLEN-32){m_lo[31]}}, m_lo[31:0]};
                            default: res_data <= m_hi;
                        endcase
                        res_valid <= 1'b1;
                        state     <= S_DONE;
                        if (REUSE_EN) begin
                            cache_valid  <= 1'b1;
                            cache_op1    <= m_op1;
                            cache_op2    <= m_op2;
                            cache_signed <= m_signed;
                            cache_mulw   <= m_mulw;
                            cache_hi     <= m_hi;
                            cache_lo     <= m_lo;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22051013_mul_ctrl.sv
// Directed bench for ysyx_22051013_mul_ctrl with a behavioural multiplier.
module tb_ysyx_22051013_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  mul_op = 3'd0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_data;
    logic        m_valid;
    logic [1:0]  m_signed;
    logic        m_mulw;
    logic [63:0] m_op1;
    logic [63:0] m_op2;
    logic        m_flush;
    logic        m_ready;
    logic        m_out_valid = 1'b0;
    logic [63:0] m_hi = '0;
    logic [63:0] m_lo = '0;

    int n_checks = 0;
    int n_errors = 0;
    int issue_cnt = 0;
    int lat_cfg = 2;

    // Behavioural multiplier state.
    logic        mdl_busy = 1'b0;
    int          mdl_cnt = 0;
    logic [63:0] mdl_a = '0;
    logic [63:0] mdl_b = '0;
    logic [1:0]  mdl_signed = '0;
    logic        mdl_mulw = 1'b0;

    ysyx_22051013_mul_ctrl #(.XLEN(64), .REUSE_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .mul_op(mul_op),
        .src1(src1), .src2(src2), .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .m_valid(m_valid), .m_signed(m_signed), .m_mulw(m_mulw),
        .m_op1(m_op1), .m_op2(m_op2), .m_flush(m_flush),
        .m_ready(m_ready), .m_out_valid(m_out_valid), .m_hi(m_hi), .m_lo(m_lo)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                              input logic [1:0] sg, input logic mw);
        logic [127:0] x;
        logic [127:0] y;
        if (mw) begin
            x = {{96{a[31]}}, a[31:0]};
            y = {{96{b[31]}}, b[31:0]};
        end else begin
            x = sg[0] ? {{64{a[63]}}, a} : {64'b0, a};
            y = sg[1] ? {{64{b[63]}}, b} : {64'b0, b};
        end
        return x * y;
    endfunction

    assign m_ready = ~mdl_busy;

    // Multiplier model: latches on m_valid, answers lat_cfg+1 cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_busy    <= 1'b0;
            m_out_valid <= 1'b0;
        end else begin
            m_out_valid <= 1'b0;
            if (m_flush) begin
                mdl_busy <= 1'b0;
            end else if (m_valid) begin
                mdl_busy   <= 1'b1;
                mdl_cnt    <= lat_cfg;
                mdl_a      <= m_op1;
                mdl_b      <= m_op2;
                mdl_signed <= m_signed;
                mdl_mulw   <= m_mulw;
            end else if (mdl_busy) begin
                if (mdl_cnt == 0) begin
                    m_out_valid   <= 1'b1;
                    {m_hi, m_lo}  <= ref_prod(mdl_a, mdl_b, mdl_signed, mdl_mulw);
                    mdl_busy      <= 1'b0;
                end else begin
                    mdl_cnt <= mdl_cnt - 1;
                end
            end
        end
    end

    // Count cycles with m_valid high (one per issued multiply).
    always @(posedge clk) begin
        if (m_valid) issue_cnt <= issue_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Run one op from accept to result transfer; hold res_ready low for 'hold' cycles.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int hold, output logic [63:0] res, output int lat, output int iss);
        int n;
        int base;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        base = issue_cnt;
        in_valid = 1'b1;
        mul_op = op;
        src1 = a;
        src2 = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid) check("res_valid_timeout", 64'(res_valid), 64'd1);
        res = res_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_data", res_data, res);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        iss = issue_cnt - base;
    endtask

    localparam logic [63:0] A = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] B = 64'h0FED_CBA9_8765_4321;

    initial begin
        logic [63:0]  r;
        logic [127:0] p;
        int           lat;
        int           iss;
        int           base;
        int           n;
        logic         seen;

        // Reset values while reset is held.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", res_data, 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_signed", 64'(m_signed), 64'd0);
        check("rst_m_op1", m_op1, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // MUL 3x5, result held 3 cycles.
        run_op(3'd0, 64'd3, 64'd5, 3, r, lat, iss);
        check("mul_res", r, 64'h0F);
        check("mul_issue", 64'(iss), 64'd1);
        check("mul_signed", 64'(mdl_signed), 64'd3);

        // MULHU -1 x -1.
        run_op(3'd3, '1, '1, 0, r, lat, iss);
        check("mulhu_res", r, 64'hFFFF_FFFF_FFFF_FFFE);
        check("mulhu_signed", 64'(mdl_signed), 64'd0);
        check("mulhu_issue", 64'(iss), 64'd1);

        // MULH -1 x -1 misses the MULHU entry (different signedness).
        run_op(3'd1, '1, '1, 0, r, lat, iss);
        check("mulh_res", r, 64'd0);
        check("mulh_signed", 64'(mdl_signed), 64'd3);
        check("mulh_issue", 64'(iss), 64'd1);

        // MULW 0x7FFFFFFF x 2.
        run_op(3'd4, 64'h7FFF_FFFF, 64'd2, 0, r, lat, iss);
        check("mulw_res", r, 64'hFFFF_FFFF_FFFF_FFFE);
        check("mulw_mode", 64'(mdl_mulw), 64'd1);

        // MULHSU -1 x 2.
        run_op(3'd2, '1, 64'd2, 0, r, lat, iss);
        check("mulhsu_res", r, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mulhsu_signed", 64'(mdl_signed), 64'd1);

        // MULH a,b then MUL a,b from the cache, then MULHU a,b misses.
        lat_cfg = 6;
        run_op(3'd1, A, B, 0, r, lat, iss);
        p = ref_prod(A, B, 2'b11, 1'b0);
        check("pair_mulh_res", r, p[127:64]);
        run_op(3'd0, A, B, 0, r, lat, iss);
        check("pair_mul_res", r, p[63:0]);
        check("pair_mul_issue", 64'(iss), 64'd0);
        check("pair_mul_lat", 64'(lat), 64'd1);
        run_op(3'd3, A, B, 0, r, lat, iss);
        p = ref_prod(A, B, 2'b00, 1'b0);
        check("pair_mulhu_res", r, p[127:64]);
        check("pair_mulhu_issue", 64'(iss), 64'd1);

        // Reserved op: result 0, no multiply.
        run_op(3'd5, 64'd9, 64'd9, 0, r, lat, iss);
        check("rsv_res", r, 64'd0);
        check("rsv_issue", 64'(iss), 64'd0);
        check("rsv_lat", 64'(lat), 64'd1);

        // Flush together with in_valid in IDLE: nothing accepted.
        base = issue_cnt;
        in_valid = 1'b1; mul_op = 3'd0; src1 = 64'd2; src2 = 64'd2; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        repeat (5) @(negedge clk);
        check("flush_acc_valid", 64'(res_valid), 64'd0);
        check("flush_acc_issue", 64'(issue_cnt - base), 64'd0);

        // Flush 5 cycles into BUSY.
        lat_cfg = 20;
        in_valid = 1'b1; mul_op = 3'd0; src1 = 64'd100; src2 = 64'd200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        flush = 1'b1;
        #1;
        check("busy_m_flush", 64'(m_flush), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        check("busy_flush_idle", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("busy_flush_nores", 64'(seen), 64'd0);
        lat_cfg = 3;
        run_op(3'd0, 64'd7, 64'd6, 0, r, lat, iss);
        check("after_flush_res", r, 64'h2A);

        // Flush coinciding with m_out_valid: no result, no cache write.
        in_valid = 1'b1; mul_op = 3'd0; src1 = 64'd11; src2 = 64'd13;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!m_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ov_seen", 64'(m_out_valid), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("ov_flush_nores", 64'(seen), 64'd0);
        run_op(3'd0, 64'd11, 64'd13, 0, r, lat, iss);
        check("ov_reissue", 64'(iss), 64'd1);
        check("ov_res", r, 64'd143);

        // Result held 10 cycles with res_ready low.
        run_op(3'd0, 64'd9, 64'd9, 10, r, lat, iss);
        check("hold10_res", r, 64'd81);

        // Async reset mid-BUSY clears outputs and the cache.
        run_op(3'd0, A, B, 0, r, lat, iss);
        lat_cfg = 20;
        in_valid = 1'b1; mul_op = 3'd0; src1 = 64'd5; src2 = 64'd5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_m_valid", 64'(m_valid), 64'd0);
        check("arst_m_op1", m_op1, 64'd0);
        check("arst_m_signed", 64'(m_signed), 64'd0);
        check("arst_res_valid", 64'(res_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        lat_cfg = 2;
        run_op(3'd0, A, B, 0, r, lat, iss);
        p = ref_prod(A, B, 2'b11, 1'b0);
        check("arst_reissue", 64'(iss), 64'd1);
        check("arst_res", r, p[63:0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
